// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
package mips_mem_pkg;

  localparam int DATA_W    = 32;
  localparam int LANE_W    = 8;
  localparam int NUM_LANES = DATA_W / LANE_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [NUM_LANES-1:0] BE_WORD    = 4'b1111;
  localparam logic [NUM_LANES-1:0] BE_HALF_LO = 4'b0011;
  localparam logic [NUM_LANES-1:0] BE_HALF_HI = 4'b1100;
  localparam logic [NUM_LANES-1:0] BE_BYTE0   = 4'b0001;

  typedef struct packed {
    logic                  isStore;
    logic                  misaligned;
    logic [NUM_LANES-1:0]  be;
    logic [DATA_W-1:0]     wdata;
  } memReq_t;

  // Word accesses must be word aligned; halfword stores additionally need an even address.
  function automatic logic isMisaligned(input logic [1:0] lowBits,
                                        input logic [NUM_LANES-1:0] be,
                                        input logic store);
    logic halfStore;
    halfStore = store && ((be == BE_HALF_LO) || (be == BE_HALF_HI));
    return (lowBits != 2'b00) || (halfStore && lowBits[0]);
  endfunction

endpackage

// File: rtl/dmem_ram_bank.sv
// Single-port byte-lane RAM; registered read returns the word as it was before a same-edge write.
module dmem_ram_bank
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             we,
  input  logic [ADDR_W-1:0]                addr,
  input  logic [NUM_LANES-1:0]             be,
  input  logic [NUM_LANES-1:0][LANE_W-1:0] wdata,
  output logic [NUM_LANES-1:0][LANE_W-1:0] rdata
);
  localparam int DEPTH = 1 << ADDR_W;

  for (genvar l = 0; l < NUM_LANES; l++) begin : gLane
    logic [LANE_W-1:0] laneMem [DEPTH];
    logic [LANE_W-1:0] laneQ;

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
      if (en && we && be[l]) laneMem[addr] <= wdata[l];
    end

    always_ff @(posedge clk) begin
      if (rst)     laneQ <= '0;
      else if (en) laneQ <= laneMem[addr];
    end

    assign rdata[l] = laneQ;
  end

endmodule

// File: rtl/mips_data_memory_responder.sv
// MEM-stage data memory with programmable wait states and a pipeline stall output.
// Optional macro DMEM_ALIGN_CHECK_EN adds align_err and suppresses misaligned accesses.
module mips_data_memory_responder
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [31:0]          address,
  input  logic [DATA_W-1:0]    write_data,
  input  logic [NUM_LANES-1:0] byte_en,
  output logic                 resp_valid,
  output logic [DATA_W-1:0]    read_data,
  output logic                 stall
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic                 align_err
`endif
);
  logic [1:0]        state;
  logic [3:0]        waitCnt;
  logic [ADDR_W-1:0] idxQ;
  memReq_t           reqQ;
  logic              fire;
  logic              opGo;
  logic              misaligned;
  logic [DATA_W-1:0] ramRdata;

  assign req_ready  = (state == ST_IDLE) && !rst;
  assign fire       = req_valid && req_ready && (mem_read || mem_write);
  assign opGo       = (state == ST_WAIT) && (waitCnt == 4'd0);
  assign stall      = fire || (state == ST_WAIT);
  assign resp_valid = (state == ST_RESP);

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = isMisaligned(address[1:0], byte_en, mem_write);
  logic unusedAddr;
  assign unusedAddr = ^address[31:ADDR_W+2];
`else
  assign misaligned = 1'b0;
  logic unusedAddr;
  assign unusedAddr = ^{address[31:ADDR_W+2], address[1:0]};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      waitCnt <= '0;
    end else begin
      case (state)
        ST_IDLE: if (fire) begin
          state   <= ST_WAIT;
          waitCnt <= 4'(WAIT_STATES);
        end
        ST_WAIT: begin
          if (waitCnt == 4'd0) state   <= ST_RESP;
          else                 waitCnt <= waitCnt - 4'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Request fields only matter between fire and RESP, so they carry no reset.
  always_ff @(posedge clk) begin
    if (fire) begin
      idxQ <= address[ADDR_W+1:2];
      reqQ <= '{isStore: mem_write, misaligned: misaligned, be: byte_en, wdata: write_data};
    end
  end

  // Bank enable is masked by rst so an aborted store never reaches the RAM.
  dmem_ram_bank #(.ADDR_W(ADDR_W)) uBank (
    .clk   (clk),
    .rst   (rst),
    .en    (opGo && !rst),
    .we    (reqQ.isStore && !reqQ.misaligned),
    .addr  (idxQ),
    .be    (reqQ.be),
    .wdata (reqQ.wdata),
    .rdata (ramRdata)
  );

`ifdef DMEM_ALIGN_CHECK_EN
  logic respErrQ;
  // Tracks the error of the response currently held on read_data.
  always_ff @(posedge clk) begin
    if (rst)       respErrQ <= 1'b0;
    else if (opGo) respErrQ <= reqQ.misaligned;
  end
  assign align_err = resp_valid && respErrQ;
  assign read_data = respErrQ ? '0 : ramRdata;
`else
  assign read_data = ramRdata;
`endif

endmodule

// File: tb/tb_mips_data_memory_responder.sv
// Scoreboard bench: dut 0 runs WAIT_STATES=0, dut 1 runs WAIT_STATES=2.
module tb_mips_data_memory_responder;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          fireEdge;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reqValid  [2];
  logic        reqReady  [2];
  logic        memRead   [2];
  logic        memWrite  [2];
  logic [31:0] addr      [2];
  logic [31:0] wdata     [2];
  logic [3:0]  be        [2];
  logic        respValid [2];
  logic [31:0] readData  [2];
  logic        stall     [2];
  logic        alignErr  [2];

  logic [31:0] model [2][256];
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int cyc = 0;
  int passCnt = 0;
  int totalCnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mips_data_memory_responder #(.ADDR_W(8), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(reqValid[0]), .req_ready(reqReady[0]),
    .mem_read(memRead[0]), .mem_write(memWrite[0]), .address(addr[0]),
    .write_data(wdata[0]), .byte_en(be[0]), .resp_valid(respValid[0]),
    .read_data(readData[0]), .stall(stall[0])
`ifdef DMEM_ALIGN_CHECK_EN
    , .align_err(alignErr[0])
`endif
  );

  mips_data_memory_responder #(.ADDR_W(8), .WAIT_STATES(2)) dut1 (
    .clk(clk), .rst(rst), .req_valid(reqValid[1]), .req_ready(reqReady[1]),
    .mem_read(memRead[1]), .mem_write(memWrite[1]), .address(addr[1]),
    .write_data(wdata[1]), .byte_en(be[1]), .resp_valid(respValid[1]),
    .read_data(readData[1]), .stall(stall[1])
`ifdef DMEM_ALIGN_CHECK_EN
    , .align_err(alignErr[1])
`endif
  );

`ifndef DMEM_ALIGN_CHECK_EN
  assign alignErr[0] = 1'b0;
  assign alignErr[1] = 1'b0;
`endif

  // Response monitors: pop the scoreboard and check data, latency and error flag.
  always @(negedge clk) begin
    if (respValid[0]) begin
      totalCnt++;
      if (q0.size() == 0) $display("FAIL resp0_unexpected got resp_valid=1 want 0 at cycle %0d", cyc);
      else begin
        e0 = q0.pop_front();
        if (readData[0] !== e0.data || (cyc - e0.fireEdge) != 1 || alignErr[0] !== e0.err)
          $display("FAIL resp0 data=%h want %h latency=%0d want 1 err=%b want %b",
                   readData[0], e0.data, cyc - e0.fireEdge, alignErr[0], e0.err);
        else passCnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (respValid[1]) begin
      totalCnt++;
      if (q1.size() == 0) $display("FAIL resp1_unexpected got resp_valid=1 want 0 at cycle %0d", cyc);
      else begin
        e1 = q1.pop_front();
        if (readData[1] !== e1.data || (cyc - e1.fireEdge) != 3 || alignErr[1] !== e1.err)
          $display("FAIL resp1 data=%h want %h latency=%0d want 3 err=%b want %b",
                   readData[1], e1.data, cyc - e1.fireEdge, alignErr[1], e1.err);
        else passCnt++;
      end
    end
  end

  // Present a request, wait for acceptance, update the model and push the expectation.
  // Returns just after the fire edge with req_valid still high.
  task automatic doReq(input int d, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd, input logic [3:0] b);
    exp_t e;
    int n;
    logic [7:0] idx;
    logic err;
    @(negedge clk);
    reqValid[d] = 1'b1; memRead[d] = rd; memWrite[d] = wr;
    addr[d] = a; wdata[d] = wd; be[d] = b;
    #1;
    n = 0;
    while (!reqReady[d] && n < 40) begin @(negedge clk); #1; n++; end
    if (!reqReady[d]) begin
      totalCnt++;
      $display("FAIL accept_timeout dut%0d req_ready=0 want 1", d);
      reqValid[d] = 1'b0;
      return;
    end
    totalCnt++;
    if (stall[d] !== 1'b1) $display("FAIL fire_stall dut%0d stall=%b want 1", d, stall[d]);
    else passCnt++;
    idx = a[9:2];
`ifdef DMEM_ALIGN_CHECK_EN
    err = (a[1:0] != 2'b00) || (wr && (b == 4'b0011 || b == 4'b1100) && a[0]);
`else
    err = 1'b0;
`endif
    e.data = err ? 32'h0 : model[d][idx];
    e.err = err;
    e.fireEdge = cyc + 1;
    if (wr && !err)
      for (int l = 0; l < 4; l++)
        if (b[l]) model[d][idx][8*l +: 8] = wd[8*l +: 8];
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic waitDone(input int d);
    int n;
    n = 0;
    while (((d == 0) ? q0.size() : q1.size()) != 0 && n < 40) begin @(negedge clk); n++; end
    if (((d == 0) ? q0.size() : q1.size()) != 0) begin
      totalCnt++;
      $display("FAIL resp_timeout dut%0d response missing want resp_valid", d);
    end
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      reqValid[d] = 0; memRead[d] = 0; memWrite[d] = 0;
      addr[d] = 0; wdata[d] = 0; be[d] = 0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      totalCnt++;
      if (reqReady[d] !== 1'b0 || respValid[d] !== 1'b0 || stall[d] !== 1'b0 || readData[d] !== 32'h0)
        $display("FAIL reset_state dut%0d ready=%b valid=%b stall=%b rdata=%h want 0 0 0 0",
                 d, reqReady[d], respValid[d], stall[d], readData[d]);
      else passCnt++;
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      totalCnt++;
      if (reqReady[d] !== 1'b1) $display("FAIL ready_after_reset dut%0d got %b want 1", d, reqReady[d]);
      else passCnt++;
    end
  endtask

  task automatic test_store_load();
    int n;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) doReq(1, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF);
      else        doReq(1, 1, 0, 32'h10, 32'h0, 4'h0);
      reqValid[1] = 1'b0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk); #1;
        if (respValid[1]) break;
        if (stall[1]) n++;
      end
      totalCnt++;
      if (n != 3 || stall[1] !== 1'b0)
        $display("FAIL stall_window access%0d stall_cycles=%0d want 3 resp_stall=%b want 0", k, n, stall[1]);
      else passCnt++;
      waitDone(1);
    end
  endtask

  task automatic test_byte_lane();
    doReq(1, 0, 1, 32'h10, 32'h11223344, 4'hF);
    doReq(1, 0, 1, 32'h10, 32'hAABBCCDD, 4'b0010);
    doReq(1, 1, 0, 32'h10, 32'h0, 4'h0);
    reqValid[1] = 1'b0;
    waitDone(1);
    totalCnt++;
    if (readData[1] !== 32'h1122CC44) $display("FAIL byte_lane_hold got %h want 1122cc44", readData[1]);
    else passCnt++;
  endtask

  task automatic test_wrap();
    doReq(1, 0, 1, 32'h400, 32'h5, 4'hF);
    doReq(1, 1, 0, 32'h0, 32'h0, 4'h0);
    reqValid[1] = 1'b0;
    waitDone(1);
    totalCnt++;
    if (readData[1] !== 32'h5) $display("FAIL wrap got %h want 00000005", readData[1]);
    else passCnt++;
  endtask

  task automatic test_back_to_back();
    doReq(0, 0, 1, 32'h0, 32'hA0A0A0A0, 4'hF);
    doReq(0, 0, 1, 32'h4, 32'hB1B1B1B1, 4'hF);
    doReq(0, 0, 1, 32'h8, 32'hC2C2C2C2, 4'hF);
    doReq(0, 1, 0, 32'h0, 32'h0, 4'h0);
    doReq(0, 1, 0, 32'h4, 32'h0, 4'h0);
    doReq(0, 1, 0, 32'h8, 32'h0, 4'h0);
    reqValid[0] = 1'b0;
    waitDone(0);
  endtask

  task automatic test_reset_midop();
    logic [31:0] saved;
    int n;
    doReq(1, 0, 1, 32'h20, 32'h12345678, 4'hF);
    reqValid[1] = 1'b0;
    waitDone(1);
    saved = model[1][8];
    doReq(1, 0, 1, 32'h20, 32'hFFFFFFFF, 4'hF);
    reqValid[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    q1.delete();
    model[1][8] = saved;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); #1; if (respValid[1]) n++; end
    totalCnt++;
    if (n != 0) $display("FAIL abort_no_resp got %0d responses want 0", n);
    else passCnt++;
    doReq(1, 1, 0, 32'h20, 32'h0, 4'h0);
    reqValid[1] = 1'b0;
    waitDone(1);
  endtask

  task automatic test_rw_both();
    doReq(1, 0, 1, 32'hC, 32'h1, 4'hF);
    doReq(1, 1, 1, 32'hC, 32'h2, 4'hF);
    reqValid[1] = 1'b0;
    waitDone(1);
    totalCnt++;
    if (readData[1] !== 32'h1) $display("FAIL rw_pre_write got %h want 00000001", readData[1]);
    else passCnt++;
    doReq(1, 1, 0, 32'hC, 32'h0, 4'h0);
    reqValid[1] = 1'b0;
    waitDone(1);
    repeat (3) @(negedge clk);
    #1;
    totalCnt++;
    if (readData[1] !== 32'h2) $display("FAIL rdata_hold got %h want 00000002", readData[1]);
    else passCnt++;
`ifdef DMEM_ALIGN_CHECK_EN
    doReq(1, 1, 0, 32'hD, 32'h0, 4'h0);
    reqValid[1] = 1'b0;
    waitDone(1);
`endif
  endtask

  task automatic test_noop();
    @(negedge clk);
    reqValid[1] = 1'b1; memRead[1] = 1'b0; memWrite[1] = 1'b0; addr[1] = 32'h10;
    #1;
    totalCnt++;
    if (stall[1] !== 1'b0) $display("FAIL noop_stall got %b want 0", stall[1]);
    else passCnt++;
    repeat (4) @(negedge clk);
    #1;
    totalCnt++;
    if (reqReady[1] !== 1'b1 || respValid[1] !== 1'b0)
      $display("FAIL noop_state ready=%b valid=%b want 1 0", reqReady[1], respValid[1]);
    else passCnt++;
    reqValid[1] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_lane();
    test_wrap();
    test_back_to_back();
    test_reset_midop();
    test_rw_both();
    test_noop();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
